// File: rtl/io_bridge.sv
// Memory-mapped bridge between the mini_rv data port and the board peripherals:
// display register, debounced slide-switch word and a switch-change flag.
module io_bridge #(
  parameter logic [19:0] DEB_CYCLES = 20'd500000,
  parameter logic [31:0] LED_ADDR   = 32'hFFFF_F000,
  parameter logic [31:0] SW_ADDR    = 32'hFFFF_F070,
  parameter logic [31:0] STAT_ADDR  = 32'hFFFF_F074
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] cpu_addr,
  input  logic        cpu_we,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  input  logic [23:0] device_sw,
  output logic [31:0] display_number,
  output logic        sw_irq
);

  localparam logic [19:0] DEB_LAST = DEB_CYCLES - 20'd1;

  logic [31:0] display_q, display_d;
  logic [23:0] sw_s1_q, sw_s1_d;
  logic [23:0] sw_s2_q, sw_s2_d;
  logic [23:0] sw_cand_q, sw_cand_d;
  logic [23:0] sw_stable_q, sw_stable_d;
  logic [19:0] deb_cnt_q, deb_cnt_d;
  logic        sw_chg_q, sw_chg_d;

  logic hit_led, hit_sw, hit_stat;
  logic chg_set, chg_clr;
  logic unused_addr_bits;

  // Byte offset within the word plays no part in decode.
  assign unused_addr_bits = ^cpu_addr[1:0];

  assign hit_led  = (cpu_addr[31:2] == LED_ADDR[31:2]);
  assign hit_sw   = (cpu_addr[31:2] == SW_ADDR[31:2]);
  assign hit_stat = (cpu_addr[31:2] == STAT_ADDR[31:2]);

  always_comb begin
    display_d   = display_q;
    sw_s1_d     = device_sw;
    sw_s2_d     = sw_s1_q;
    sw_cand_d   = sw_cand_q;
    sw_stable_d = sw_stable_q;
    deb_cnt_d   = deb_cnt_q;
    chg_set     = 1'b0;
    chg_clr     = cpu_we && hit_stat && cpu_wdata[0];

    if (cpu_we && hit_led) begin
      display_d = cpu_wdata;
    end

    // Any movement of the synchronised vector restarts the stability window.
    if (sw_s2_q != sw_cand_q) begin
      sw_cand_d = sw_s2_q;
      deb_cnt_d = 20'd0;
    end else if (deb_cnt_q == DEB_LAST) begin
      sw_stable_d = sw_cand_q;
      chg_set     = (sw_cand_q != sw_stable_q);
    end else begin
      deb_cnt_d = deb_cnt_q + 20'd1;
    end

    if (chg_set) begin
      sw_chg_d = 1'b1;
    end else if (chg_clr) begin
      sw_chg_d = 1'b0;
    end else begin
      sw_chg_d = sw_chg_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      display_q   <= 32'h0;
      sw_s1_q     <= 24'h0;
      sw_s2_q     <= 24'h0;
      sw_cand_q   <= 24'h0;
      sw_stable_q <= 24'h0;
      deb_cnt_q   <= 20'd0;
      sw_chg_q    <= 1'b0;
    end else begin
      display_q   <= display_d;
      sw_s1_q     <= sw_s1_d;
      sw_s2_q     <= sw_s2_d;
      sw_cand_q   <= sw_cand_d;
      sw_stable_q <= sw_stable_d;
      deb_cnt_q   <= deb_cnt_d;
      sw_chg_q    <= sw_chg_d;
    end
  end

  always_comb begin
    cpu_rdata = 32'h0;
    if (hit_led) begin
      cpu_rdata = display_q;
    end else if (hit_sw) begin
      cpu_rdata = {8'h0, sw_stable_q};
    end else if (hit_stat) begin
      cpu_rdata = {31'h0, sw_chg_q};
    end
  end

  assign display_number = display_q;
  assign sw_irq         = sw_chg_q;

endmodule

// File: tb/tb_io_bridge.sv
// Self-checking bench for io_bridge: table-driven register/decode vectors plus
// hand-written debounce, flag-race and mid-operation reset sequences.
module tb_io_bridge;

  localparam logic [31:0] LED_A  = 32'hFFFF_F000;
  localparam logic [31:0] SW_A   = 32'hFFFF_F070;
  localparam logic [31:0] STAT_A = 32'hFFFF_F074;

  logic        clk;
  logic        rst_n;
  logic [31:0] cpu_addr;
  logic        cpu_we;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic [23:0] device_sw;
  logic [31:0] display_number;
  logic        sw_irq;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic [31:0] exp_disp;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[10];

  io_bridge #(
    .DEB_CYCLES(20'd4),
    .LED_ADDR  (LED_A),
    .SW_ADDR   (SW_A),
    .STAT_ADDR (STAT_A)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cpu_addr      (cpu_addr),
    .cpu_we        (cpu_we),
    .cpu_wdata     (cpu_wdata),
    .cpu_rdata     (cpu_rdata),
    .device_sw     (device_sw),
    .display_number(display_number),
    .sw_irq        (sw_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    device_sw = 24'h0;
    applyStimulus(1'b0, 32'h0, 32'h0);

    vecs[0] = '{1'b1, LED_A,         32'h1234_5678, 32'h0,          32'h1234_5678, 1'b0};
    vecs[1] = '{1'b0, LED_A,         32'h0,         32'h1234_5678,  32'h1234_5678, 1'b0};
    vecs[2] = '{1'b1, LED_A,         32'hDEAD_BEEF, 32'h1234_5678,  32'hDEAD_BEEF, 1'b0};
    vecs[3] = '{1'b1, 32'hFFFF_F010, 32'hFFFF_FFFF, 32'h0,          32'hDEAD_BEEF, 1'b0};
    vecs[4] = '{1'b0, 32'hFFFF_F010, 32'h0,         32'h0,          32'hDEAD_BEEF, 1'b0};
    vecs[5] = '{1'b1, SW_A,          32'hFFFF_FFFF, 32'h0,          32'hDEAD_BEEF, 1'b0};
    vecs[6] = '{1'b0, STAT_A,        32'h0,         32'h0,          32'hDEAD_BEEF, 1'b0};
    vecs[7] = '{1'b1, 32'hFFFF_F003, 32'h0BAD_F00D, 32'hDEAD_BEEF,  32'h0BAD_F00D, 1'b0};
    vecs[8] = '{1'b1, 32'hFFFF_F004, 32'h1111_1111, 32'h0,          32'h0BAD_F00D, 1'b0};
    vecs[9] = '{1'b1, STAT_A,        32'h1,         32'h0,          32'h0BAD_F00D, 1'b0};

    $display("[TB] reset state");
    tick();
    tick();
    checkOutput("reset display", display_number, 32'h0);
    checkOutput("reset irq", {31'h0, sw_irq}, 32'h0);
    applyStimulus(1'b0, LED_A, 32'h0);  #1 checkOutput("reset rd led", cpu_rdata, 32'h0);
    applyStimulus(1'b0, SW_A, 32'h0);   #1 checkOutput("reset rd sw", cpu_rdata, 32'h0);
    applyStimulus(1'b0, STAT_A, 32'h0); #1 checkOutput("reset rd stat", cpu_rdata, 32'h0);
    rst_n = 1'b1;
    tick();

    $display("[TB] register and decode vectors");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].wdata);
      #1;
      checkOutput($sformatf("vec%0d rdata", i), cpu_rdata, vecs[i].exp_rdata);
      tick();
      checkOutput($sformatf("vec%0d display", i), display_number, vecs[i].exp_disp);
      checkOutput($sformatf("vec%0d irq", i), {31'h0, sw_irq}, {31'h0, vecs[i].exp_irq});
    end

    $display("[TB] debounce accept");
    applyStimulus(1'b0, SW_A, 32'h0);
    device_sw = 24'hA5_0F3C;
    for (int i = 0; i < 6; i++) tick();
    checkOutput("accept early sw", cpu_rdata, 32'h0);
    checkOutput("accept early irq", {31'h0, sw_irq}, 32'h0);
    tick();
    checkOutput("accept sw", cpu_rdata, 32'h00A5_0F3C);
    checkOutput("accept irq", {31'h0, sw_irq}, 32'h1);

    $display("[TB] flag clear");
    applyStimulus(1'b1, STAT_A, 32'h1);
    #1 checkOutput("stat read set", cpu_rdata, 32'h1);
    tick();
    checkOutput("clear irq", {31'h0, sw_irq}, 32'h0);
    applyStimulus(1'b0, SW_A, 32'h0);

    $display("[TB] glitch reject");
    device_sw = 24'hA5_0F3D;
    for (int i = 0; i < 3; i++) tick();
    device_sw = 24'hA5_0F3C;
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput($sformatf("glitch irq c%0d", i), {31'h0, sw_irq}, 32'h0);
    end
    checkOutput("glitch sw", cpu_rdata, 32'h00A5_0F3C);

    $display("[TB] set/clear race");
    device_sw = 24'h00_0001;
    for (int i = 0; i < 6; i++) tick();
    checkOutput("race pre irq", {31'h0, sw_irq}, 32'h0);
    checkOutput("race pre sw", cpu_rdata, 32'h00A5_0F3C);
    applyStimulus(1'b1, STAT_A, 32'h1);
    tick();
    checkOutput("race irq", {31'h0, sw_irq}, 32'h1);
    applyStimulus(1'b0, SW_A, 32'h0);
    #1 checkOutput("race sw", cpu_rdata, 32'h0000_0001);
    applyStimulus(1'b1, STAT_A, 32'h1);
    tick();
    checkOutput("race clear irq", {31'h0, sw_irq}, 32'h0);

    $display("[TB] reset mid-debounce");
    applyStimulus(1'b0, SW_A, 32'h0);
    device_sw = 24'h12_3456;
    for (int i = 0; i < 3; i++) tick();
    rst_n = 1'b0;
    #1;
    checkOutput("midrst display", display_number, 32'h0);
    checkOutput("midrst irq", {31'h0, sw_irq}, 32'h0);
    checkOutput("midrst rd sw", cpu_rdata, 32'h0);
    applyStimulus(1'b0, LED_A, 32'h0);  #1 checkOutput("midrst rd led", cpu_rdata, 32'h0);
    applyStimulus(1'b0, STAT_A, 32'h0); #1 checkOutput("midrst rd stat", cpu_rdata, 32'h0);
    applyStimulus(1'b0, SW_A, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    checkOutput("postrst early sw", cpu_rdata, 32'h0);
    checkOutput("postrst early irq", {31'h0, sw_irq}, 32'h0);
    tick();
    checkOutput("postrst sw", cpu_rdata, 32'h0012_3456);
    checkOutput("postrst irq", {31'h0, sw_irq}, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
